// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, drives an external registered ALU,
// waits LATENCY cycles, then returns the captured result through a response handshake.
// Build option: define ALU_SEQ_OVF_TRAP_EN to add a sticky overflow trap. While the trap
// is set, new requests are blocked until trap_clr. Without the macro, trap is tied low and
// trap_clr is ignored.
module alu_sequencer #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    // Request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    // Registered ALU side
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    // Response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_illegal,
    // Sticky overflow trap
    output logic        trap,
    input  logic        trap_clr
);

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctXor = 6'b100110;

    localparam logic [2:0] CtrlAdd  = 3'b000;
    localparam logic [2:0] CtrlSub  = 3'b001;
    localparam logic [2:0] CtrlXor  = 3'b010;
    localparam logic [2:0] CtrlNone = 3'b111;

    // ISSUE loads LATENCY-1 so WAIT lasts exactly LATENCY cycles
    localparam logic [3:0] WaitLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Latched request
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        illegal_q, illegal_d;

    // Response payload
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        rsp_ovf_q, rsp_ovf_d;
    logic        rsp_illegal_q, rsp_illegal_d;

    logic [2:0]  dec_ctrl;
    logic        dec_illegal;
    logic        accept;
    logic        capture;
    logic        busy;
    logic        cap_ovf;

    // Decode the incoming funct code into an ALU control word
    always_comb begin
        dec_ctrl    = CtrlNone;
        dec_illegal = 1'b1;
        case (req_op)
            FunctAdd: begin
                dec_ctrl    = CtrlAdd;
                dec_illegal = 1'b0;
            end
            FunctSub: begin
                dec_ctrl    = CtrlSub;
                dec_illegal = 1'b0;
            end
            FunctXor: begin
                dec_ctrl    = CtrlXor;
                dec_illegal = 1'b0;
            end
            default: begin
                dec_ctrl    = CtrlNone;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign req_ready = (state_q == StIdle) && !trap;
    assign accept    = req_valid && req_ready;
    assign capture   = (state_q == StWait) && (cnt_q == '0);
    assign busy      = (state_q == StIssue) || (state_q == StWait);

    // Overflow is only meaningful for arithmetic ops; XOR and illegal ops never flag it
    assign cap_ovf = ((ctrl_q == CtrlAdd) || (ctrl_q == CtrlSub)) && alu_ovf;

    // Next-state logic: request latch, wait counter and state transitions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_a_d    = req_a;
                    op_b_d    = req_b;
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = WaitLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response payload capture; it holds until the next capture
    always_comb begin
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_illegal_d = rsp_illegal_q;
        if (capture) begin
            rsp_data_d    = illegal_q ? 32'h0 : alu_r;
            rsp_zero_d    = illegal_q ? 1'b1 : alu_zero;
            rsp_ovf_d     = cap_ovf;
            rsp_illegal_d = illegal_q;
        end
    end

    // State, request latch and payload registers; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            ctrl_q        <= CtrlNone;
            illegal_q     <= 1'b0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            ctrl_q        <= ctrl_d;
            illegal_q     <= illegal_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // ALU operands are only driven while the op is in flight
    assign alu_a    = busy ? op_a_q : 32'h0;
    assign alu_b    = busy ? op_b_q : 32'h0;
    assign alu_ctrl = busy ? ctrl_q : CtrlNone;

    assign rsp_valid   = (state_q == StResp);
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;

`ifdef ALU_SEQ_OVF_TRAP_EN
    logic trap_q, trap_d;

    // Sticky trap: a set on the RESP-entry edge wins over a simultaneous clear
    always_comb begin
        trap_d = trap_q;
        if (trap_clr) begin
            trap_d = 1'b0;
        end
        if (capture && cap_ovf) begin
            trap_d = 1'b1;
        end
    end

    // Trap register
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap = trap_q;
`else
    logic unused_trap_clr;

    assign unused_trap_clr = trap_clr;
    assign trap            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer.
// The driver pushes the expected response at each accept. A negedge monitor pops and
// compares each response at its handshake. The monitor also checks the ALU drive, the
// latency, stall stability and the trap. The external ALU is modelled here as a registered
// unit whose ovf flag is unsigned carry/borrow, so 0xFFFFFFFF + 1 reports ovf=1.
// LATENCY is 3 here: a response appears LATENCY+1 = 4 edges after the accepting edge.
module tb_alu_sequencer;

    localparam int unsigned LAT = 3;
    localparam logic [5:0] OpAdd = 6'h20;
    localparam logic [5:0] OpSub = 6'h22;
    localparam logic [5:0] OpXor = 6'h26;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_r = '0;
    logic        alu_zero = 1'b0;
    logic        alu_ovf = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_ovf, rsp_illegal;
    logic        trap;
    logic        trap_clr = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        illegal;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic        in_resp = 1'b0;
    logic        model_trap = 1'b0;
    logic [31:0] snap_data;
    logic [2:0]  snap_flags;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_sequencer #(
        .LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_r      (alu_r),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
        .rsp_illegal(rsp_illegal),
        .trap       (trap),
        .trap_clr   (trap_clr)
    );

    // External ALU: {zero, ovf, r}; XOR and unknown controls emit junk flags.
    function automatic logic [33:0] alu_model(input logic [2:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] t;
        case (c)
            3'b000:  t = {1'b0, a} + {1'b0, b};
            3'b001:  t = {1'b0, a} - {1'b0, b};
            3'b010:  t = {a[0], a ^ b};
            default: t = {1'b1, ~(a ^ b) | 32'h1};
        endcase
        return {(t[31:0] == 32'h0), t};
    endfunction

    always @(posedge clk) {alu_zero, alu_ovf, alu_r} <= alu_model(alu_ctrl, alu_a, alu_b);

    // Reference: expected response computed directly from the request
    function automatic exp_t ref_rsp(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.illegal = 1'b0;
        e.ovf = 1'b0;
        e.acc = 0;
        if (op == OpAdd) begin
            e.ctrl = 3'b000;
            e.data = a + b;
            e.ovf  = (a > 32'hFFFF_FFFF - b);
        end else if (op == OpSub) begin
            e.ctrl = 3'b001;
            e.data = a - b;
            e.ovf  = (a < b);
        end else if (op == OpXor) begin
            e.ctrl = 3'b010;
            e.data = a ^ b;
        end else begin
            e.ctrl = 3'b111;
            e.data = 32'h0;
            e.illegal = 1'b1;
        end
        e.zero = (e.data == 32'h0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, expv);
        end
    endtask

    // Response-ready driver: 0 always ready, 1 random back-pressure, 2 held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
`ifndef ALU_SEQ_OVF_TRAP_EN
            trap_clr = $urandom_range(0, 1) != 0;
`endif
        end
    end

    // Monitor: response scoreboard plus per-cycle interface checks
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid) begin
                    check("rsp_req_ready", 32'(req_ready), 32'd0);
                    check("rsp_alu_ctrl", 32'(alu_ctrl), 32'd7);
                    check("rsp_alu_a", alu_a, 32'h0);
                    if (!in_resp) begin
                        check("rsp_has_expect", 32'(sb.size() != 0), 32'd1);
                        if (sb.size() != 0) begin
                            check("latency", 32'(cyc - sb[0].acc), 32'(LAT + 2));
                            if (sb[0].ovf) model_trap = 1'b1;
                        end
                        in_resp = 1'b1;
                        snap_data = rsp_data;
                        snap_flags = {rsp_zero, rsp_ovf, rsp_illegal};
                    end else begin
                        check("stall_data", rsp_data, snap_data);
                        check("stall_flags", 32'({rsp_zero, rsp_ovf, rsp_illegal}),
                              32'(snap_flags));
                    end
                    if (rsp_ready) begin
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("rsp_data", rsp_data, e.data);
                            check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                            check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                            check("rsp_illegal", 32'(rsp_illegal), 32'(e.illegal));
                        end
                        in_resp = 1'b0;
                    end
                end else if (sb.size() != 0 && cyc > sb[0].acc &&
                             cyc <= sb[0].acc + int'(LAT) + 1) begin
                    check("busy_alu_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
                    check("busy_alu_a", alu_a, sb[0].a);
                    check("busy_alu_b", alu_b, sb[0].b);
                    check("busy_req_ready", 32'(req_ready), 32'd0);
                end else begin
                    check("idle_alu_ctrl", 32'(alu_ctrl), 32'd7);
                    check("idle_alu_ab", alu_a | alu_b, 32'h0);
                end
`ifdef ALU_SEQ_OVF_TRAP_EN
                check("trap", 32'(trap), 32'(model_trap));
`else
                check("trap_const0", 32'(trap), 32'd0);
`endif
            end
        end
    end

    // Issue one request; junk drives req_* while the op is in flight, then returns on RESP entry
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic clr_on_set);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 300) begin
                check("accept_timeout", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        check("one_outstanding", 32'(sb.size()), 32'd0);
        e = ref_rsp(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        for (int i = 0; i <= int'(LAT); i++) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom_range(0, 1) != 0);
            req_op = 6'($urandom);
            req_a = $urandom;
            req_b = $urandom;
`ifdef ALU_SEQ_OVF_TRAP_EN
            if (i == int'(LAT)) trap_clr = clr_on_set;
`endif
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
        trap_clr = 1'b0;
`endif
    endtask

    // Wait for all responses to drain; with the trap build, verify and clear a pending trap
    task automatic settle();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
`ifdef ALU_SEQ_OVF_TRAP_EN
        if (model_trap) begin
            @(negedge clk);
            check("trap_blocks_req", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1 trap_clr = 1'b1;
            @(posedge clk);
            #1 trap_clr = 1'b0;
            model_trap = 1'b0;
            @(negedge clk);
            check("req_ready_after_clr", 32'(req_ready), 32'd1);
        end
`endif
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: bench did not finish (tests %0d)", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic [5:0] op;

        // Reset and reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_flags", 32'({rsp_zero, rsp_ovf, rsp_illegal}), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd7);
        check("rst_alu_ab", alu_a | alu_b, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Illegal op, then back-to-back SUB / XOR
        send(6'h2A, 32'd3, 32'd4, 1'b0);
        settle();
        send(OpSub, 32'd5, 32'd5, 1'b0);
        send(OpXor, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
        settle();

        // Stalled response: held three cycles, then released
        rdy_mode = 2;
        send(OpAdd, 32'd1, 32'd2, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_value", rsp_data, 32'h3);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rdy_mode = 0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("idle_after_rsp", 32'(req_ready), 32'd1);
        check("idle_after_rsp_valid", 32'(rsp_valid), 32'd0);

        // Carry-out add
        send(OpAdd, 32'hFFFF_FFFF, 32'h1, 1'b0);
        settle();

        // Reset in the middle of WAIT aborts the op
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op = OpAdd;
        req_a = 32'd7;
        req_b = 32'd9;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        e = ref_rsp(OpAdd, 32'd7, 32'd9);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        in_resp = 1'b0;
        model_trap = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_alu_ctrl", 32'(alu_ctrl), 32'd7);
        repeat (12) @(negedge clk);

        // Randomized traffic with random back-pressure
        rdy_mode = 1;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 4))
                0:       op = OpAdd;
                1:       op = OpSub;
                2:       op = OpXor;
                default: op = 6'($urandom);
            endcase
`ifdef ALU_SEQ_OVF_TRAP_EN
            settle();
`endif
            send(op, pick(), pick(), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        settle();

`ifdef ALU_SEQ_OVF_TRAP_EN
        // Clear asserted on the set edge: set wins, response still delivered
        send(OpAdd, 32'h8000_0000, 32'h8000_0000, 1'b1);
        @(negedge clk);
        check("trap_set_wins", 32'(trap), 32'd1);
        settle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
